// File: rtl/bp_update_scheduler_if.sv
// Port bundle between the branch-predictor update scheduler, fetch/commit and the PHT write port.
interface bp_update_scheduler_if #(
  parameter int PHT_INDEX_WIDTH = 11,
  parameter int CNT_WIDTH       = 2,
  parameter int QUEUE_DEPTH     = 4
);
  logic                             lookup_req;
  logic                             lookup_stall;
  logic                             upd_valid;
  logic                             upd_ready;
  logic [PHT_INDEX_WIDTH-1:0]       upd_index;
  logic                             upd_taken;
  logic [CNT_WIDTH-1:0]             upd_prev_cnt;
  logic                             pht_we;
  logic [PHT_INDEX_WIDTH-1:0]       pht_waddr;
  logic [CNT_WIDTH-1:0]             pht_wdata;
  logic                             init_busy;
  logic [$clog2(QUEUE_DEPTH):0]     q_count;

  modport master (
    output lookup_req, upd_valid, upd_index, upd_taken, upd_prev_cnt,
    input  lookup_stall, upd_ready, pht_we, pht_waddr, pht_wdata, init_busy, q_count
  );

  modport slave (
    input  lookup_req, upd_valid, upd_index, upd_taken, upd_prev_cnt,
    output lookup_stall, upd_ready, pht_we, pht_waddr, pht_wdata, init_busy, q_count
  );
endinterface

// File: rtl/bp_update_scheduler.sv
// PHT write-port owner: post-reset init sweep, queued counter updates with forwarding,
// lookup-priority arbitration with a starvation guard. Includes a protocol checker module.
module bp_update_scheduler #(
  parameter int PHT_ENTRY_NUM   = 2048,
  parameter int PHT_INDEX_WIDTH = 11,
  parameter int CNT_WIDTH       = 2,
  parameter int QUEUE_DEPTH     = 4,
  parameter int STARVE_LIMIT    = 8
) (
  input logic                  clk,
  input logic                  rst,
  bp_update_scheduler_if.slave bus
);
  localparam int AW  = $clog2(QUEUE_DEPTH);
  localparam int QCW = AW + 1;
  localparam int SW  = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_WIDTH-1:0]       CNT_WNT    = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);
  localparam logic [CNT_WIDTH-1:0]       CNT_MAX    = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]       CNT_ZERO   = {CNT_WIDTH{1'b0}};
  localparam logic [PHT_INDEX_WIDTH-1:0] LAST_IDX   = PHT_INDEX_WIDTH'(PHT_ENTRY_NUM - 1);
  localparam logic [QCW-1:0]             Q_FULL     = QCW'(QUEUE_DEPTH);
  localparam logic [SW-1:0]              STARVE_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                     state_r, state_s;
  logic [PHT_INDEX_WIDTH-1:0] sweep_ptr_r;
  logic [AW-1:0]              rd_ptr_r, wr_ptr_r;
  logic [QCW-1:0]             q_count_r, q_count_s;
  logic [SW-1:0]              starve_r;
  logic                       upd_ready_r;
  logic [PHT_INDEX_WIDTH-1:0] mem_idx_r [QUEUE_DEPTH];
  logic [CNT_WIDTH-1:0]       mem_cnt_r [QUEUE_DEPTH];

  logic                       pht_we_s, lookup_stall_s, enq_s, deq_s, fwd_hit_s;
  logic [PHT_INDEX_WIDTH-1:0] pht_waddr_s;
  logic [CNT_WIDTH-1:0]       pht_wdata_s, fwd_cnt_s, base_cnt_s, new_cnt_s;

  function automatic logic [CNT_WIDTH-1:0] sat_update(input logic [CNT_WIDTH-1:0] cnt,
                                                       input logic taken);
    if (taken) begin
      sat_update = (cnt == CNT_MAX) ? cnt : cnt + CNT_WIDTH'(1);
    end else begin
      sat_update = (cnt == CNT_ZERO) ? cnt : cnt - CNT_WIDTH'(1);
    end
  endfunction

  // Forwarding: scan oldest to youngest so the youngest matching queued entry wins
  always_comb begin
    fwd_hit_s = 1'b0;
    fwd_cnt_s = CNT_ZERO;
    for (int k = 0; k < QUEUE_DEPTH; k++) begin
      logic m;
      m = (QCW'(k) < q_count_r) && (mem_idx_r[rd_ptr_r + AW'(k)] == bus.upd_index);
      fwd_hit_s = fwd_hit_s | m;
      fwd_cnt_s = m ? mem_cnt_r[rd_ptr_r + AW'(k)] : fwd_cnt_s;
    end
    base_cnt_s = fwd_hit_s ? fwd_cnt_s : bus.upd_prev_cnt;
    new_cnt_s  = sat_update(base_cnt_s, bus.upd_taken);
  end

  // Next state, port arbitration and FIFO handshake decode
  always_comb begin
    state_s        = state_r;
    pht_we_s       = 1'b0;
    pht_waddr_s    = {PHT_INDEX_WIDTH{1'b0}};
    pht_wdata_s    = CNT_ZERO;
    lookup_stall_s = 1'b0;
    enq_s          = 1'b0;
    deq_s          = 1'b0;
    if (rst) begin
      state_s = ST_INIT;
    end else begin
      case (state_r)
        ST_INIT: begin
          pht_we_s       = 1'b1;
          pht_waddr_s    = sweep_ptr_r;
          pht_wdata_s    = CNT_WNT;
          lookup_stall_s = bus.lookup_req;
          state_s        = (sweep_ptr_r == LAST_IDX) ? ST_RUN : ST_INIT;
        end
        ST_RUN: begin
          enq_s          = bus.upd_valid & upd_ready_r;
          deq_s          = (q_count_r != QCW'(0)) &&
                           (!bus.lookup_req || (starve_r == STARVE_MAX));
          pht_we_s       = deq_s;
          pht_waddr_s    = deq_s ? mem_idx_r[rd_ptr_r] : {PHT_INDEX_WIDTH{1'b0}};
          pht_wdata_s    = deq_s ? mem_cnt_r[rd_ptr_r] : CNT_ZERO;
          lookup_stall_s = deq_s & bus.lookup_req;
        end
        default: state_s = ST_INIT;
      endcase
    end
    q_count_s = q_count_r + QCW'(enq_s) - QCW'(deq_s);
  end

  // Control registers: state, sweep pointer, FIFO pointers, occupancy, starvation, ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_INIT;
      sweep_ptr_r <= {PHT_INDEX_WIDTH{1'b0}};
      rd_ptr_r    <= AW'(0);
      wr_ptr_r    <= AW'(0);
      q_count_r   <= QCW'(0);
      starve_r    <= SW'(0);
      upd_ready_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      sweep_ptr_r <= (state_r == ST_INIT) ? sweep_ptr_r + PHT_INDEX_WIDTH'(1) : sweep_ptr_r;
      rd_ptr_r    <= deq_s ? rd_ptr_r + AW'(1) : rd_ptr_r;
      wr_ptr_r    <= enq_s ? wr_ptr_r + AW'(1) : wr_ptr_r;
      q_count_r   <= q_count_s;
      // A head that is not dequeued while present must be waiting on a lookup
      starve_r    <= (deq_s || (q_count_r == QCW'(0))) ? SW'(0) : starve_r + SW'(1);
      upd_ready_r <= (state_s == ST_RUN) && (q_count_s < Q_FULL);
    end
  end

  // FIFO payload storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        mem_idx_r[k] <= {PHT_INDEX_WIDTH{1'b0}};
        mem_cnt_r[k] <= CNT_ZERO;
      end
    end else if (enq_s) begin
      mem_idx_r[wr_ptr_r] <= bus.upd_index;
      mem_cnt_r[wr_ptr_r] <= new_cnt_s;
    end else begin
      mem_idx_r[wr_ptr_r] <= mem_idx_r[wr_ptr_r];
    end
  end

  assign bus.pht_we       = pht_we_s;
  assign bus.pht_waddr    = pht_waddr_s;
  assign bus.pht_wdata    = pht_wdata_s;
  assign bus.lookup_stall = lookup_stall_s;
  assign bus.upd_ready    = upd_ready_r;
  assign bus.init_busy    = (state_r == ST_INIT);
  assign bus.q_count      = q_count_r;
endmodule

// Protocol checker: no enqueue when full, no RUN-time write when empty.
module bp_update_scheduler_chk #(
  parameter int QUEUE_DEPTH = 4
) (
  input logic                         clk,
  input logic                         rst,
  input logic                         upd_valid,
  input logic                         upd_ready,
  input logic                         pht_we,
  input logic                         init_busy,
  input logic [$clog2(QUEUE_DEPTH):0] q_count
);
  localparam int QCW = $clog2(QUEUE_DEPTH) + 1;

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    (upd_valid && upd_ready) |-> (q_count < QCW'(QUEUE_DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst)
    (pht_we && !init_busy) |-> (q_count != QCW'(0)));
  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    q_count <= QCW'(QUEUE_DEPTH));
endmodule

// File: tb/tb_bp_update_scheduler.sv
// Scoreboard bench for bp_update_scheduler with a 16-entry PHT.
module tb_bp_update_scheduler;
  localparam int NE = 16;
  localparam int IW = 4;
  localparam int CW = 2;
  localparam int QD = 4;
  localparam int SL = 8;

  typedef struct packed {
    logic [IW-1:0] idx;
    logic [CW-1:0] cnt;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  wr_t  sb [$];

  always #5 clk = ~clk;

  bp_update_scheduler_if #(.PHT_INDEX_WIDTH(IW), .CNT_WIDTH(CW), .QUEUE_DEPTH(QD)) bus ();

  bp_update_scheduler #(
    .PHT_ENTRY_NUM(NE), .PHT_INDEX_WIDTH(IW), .CNT_WIDTH(CW),
    .QUEUE_DEPTH(QD), .STARVE_LIMIT(SL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  bp_update_scheduler_chk #(.QUEUE_DEPTH(QD)) u_chk (
    .clk       (clk),
    .rst       (rst),
    .upd_valid (bus.upd_valid),
    .upd_ready (bus.upd_ready),
    .pht_we    (bus.pht_we),
    .init_busy (bus.init_busy),
    .q_count   (bus.q_count)
  );

  function automatic logic [CW-1:0] exp_cnt(input int prev, input bit taken);
    int v;
    v = taken ? prev + 1 : prev - 1;
    if (v > (1 << CW) - 1) v = (1 << CW) - 1;
    if (v < 0) v = 0;
    return CW'(v);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Sample at the falling edge; any RUN-time PHT write must match the scoreboard head
  task automatic sample();
    wr_t exp;
    @(negedge clk);
    if (bus.pht_we === 1'b1 && bus.init_busy === 1'b0) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_write got addr=%0d data=%b, expected no write", bus.pht_waddr, bus.pht_wdata);
      end else begin
        exp = sb.pop_front();
        if (bus.pht_waddr !== exp.idx || bus.pht_wdata !== exp.cnt) begin
          n_errors++;
          $display("FAIL sb_write got addr=%0d data=%b, expected addr=%0d data=%b",
                   bus.pht_waddr, bus.pht_wdata, exp.idx, exp.cnt);
        end
      end
    end
  endtask

  task automatic drive_upd(input bit v, input int idx, input bit taken, input int prev);
    bus.upd_valid    = v;
    bus.upd_index    = IW'(idx);
    bus.upd_taken    = taken;
    bus.upd_prev_cnt = CW'(prev);
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) begin
      sample();
      step();
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_errors++;
      $display("FAIL drain_timeout got %0d pending writes, expected 0", sb.size());
    end
    sample();
    n_checks++;
    if (bus.q_count !== 3'd0) begin
      n_errors++;
      $display("FAIL drain_qcount got=%0d expected=0", bus.q_count);
    end
    step();
  endtask

  // Full init sweep from a just-released reset; ends with the first RUN cycle checked
  task automatic run_sweep(input string tag);
    for (int i = 0; i < NE; i++) begin
      logic lr;
      lr = (i % 2) == 1;
      bus.lookup_req = lr;
      sample();
      n_checks++;
      if (bus.pht_we !== 1'b1 || bus.pht_waddr !== IW'(i) || bus.pht_wdata !== 2'b01 ||
          bus.init_busy !== 1'b1 || bus.lookup_stall !== lr) begin
        n_errors++;
        $display("FAIL %s_sweep cyc=%0d got we=%b addr=%0d data=%b busy=%b stall=%b, expected 1 %0d 01 1 %b",
                 tag, i, bus.pht_we, bus.pht_waddr, bus.pht_wdata, bus.init_busy, bus.lookup_stall, i, lr);
      end
      step();
    end
    bus.lookup_req = 1'b0;
    sample();
    n_checks++;
    if (bus.init_busy !== 1'b0 || bus.upd_ready !== 1'b1 || bus.pht_we !== 1'b0 || bus.q_count !== 3'd0) begin
      n_errors++;
      $display("FAIL %s_run_entry got busy=%b ready=%b we=%b q=%0d, expected 0 1 0 0",
               tag, bus.init_busy, bus.upd_ready, bus.pht_we, bus.q_count);
    end
    step();
  endtask

  task automatic test_reset();
    bus.lookup_req = 1'b1;
    drive_upd(1'b0, 0, 1'b0, 0);
    rst = 1'b1;
    step();
    sample();
    n_checks++;
    if (bus.pht_we !== 1'b0 || bus.upd_ready !== 1'b0 || bus.init_busy !== 1'b1 ||
        bus.lookup_stall !== 1'b0 || bus.q_count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_outputs got we=%b ready=%b busy=%b stall=%b q=%0d, expected 0 0 1 0 0",
               bus.pht_we, bus.upd_ready, bus.init_busy, bus.lookup_stall, bus.q_count);
    end
    step();
    rst = 1'b0;
    run_sweep("reset");
  endtask

  task automatic test_single();
    bus.lookup_req = 1'b0;
    for (int n = 0; n < 2; n++) begin
      int  idx;
      bit  tk;
      int  pv;
      idx = (n == 0) ? 5 : 6;
      tk  = (n == 0);
      pv  = (n == 0) ? 3 : 0;
      drive_upd(1'b1, idx, tk, pv);
      sb.push_back('{idx: IW'(idx), cnt: exp_cnt(pv, tk)});
      sample();
      n_checks++;
      if (bus.upd_ready !== 1'b1 || bus.pht_we !== 1'b0) begin
        n_errors++;
        $display("FAIL single_accept got ready=%b we=%b, expected 1 0", bus.upd_ready, bus.pht_we);
      end
      step();
      drive_upd(1'b0, 0, 1'b0, 0);
      sample();
      n_checks++;
      if (bus.pht_we !== 1'b1) begin
        n_errors++;
        $display("FAIL single_latency got we=%b, expected 1", bus.pht_we);
      end
      step();
    end
  endtask

  task automatic test_forward();
    bus.lookup_req = 1'b1;
    drive_upd(1'b1, 9, 1'b1, 1);
    sb.push_back('{idx: IW'(9), cnt: 2'b10});
    sample();
    step();
    drive_upd(1'b1, 9, 1'b1, 1);
    sb.push_back('{idx: IW'(9), cnt: 2'b11});
    sample();
    step();
    drive_upd(1'b0, 0, 1'b0, 0);
    sample();
    n_checks++;
    if (bus.q_count !== 3'd2) begin
      n_errors++;
      $display("FAIL forward_qcount got=%0d expected=2", bus.q_count);
    end
    step();
    bus.lookup_req = 1'b0;
    drain(20);
  endtask

  task automatic test_starve();
    bus.lookup_req = 1'b1;
    drive_upd(1'b1, 3, 1'b1, 0);
    sb.push_back('{idx: IW'(3), cnt: exp_cnt(0, 1'b1)});
    sample();
    step();
    drive_upd(1'b0, 0, 1'b0, 0);
    for (int k = 1; k <= SL + 4; k++) begin
      logic want;
      want = (k == SL + 1);
      sample();
      n_checks++;
      if (bus.pht_we !== want || bus.lookup_stall !== want) begin
        n_errors++;
        $display("FAIL starve cyc=%0d got we=%b stall=%b, expected %b %b",
                 k, bus.pht_we, bus.lookup_stall, want, want);
      end
      step();
    end
    bus.lookup_req = 1'b0;
    drain(4);
  endtask

  task automatic test_back_to_back();
    bit tk [4];
    int pv [4];
    tk = '{1'b1, 1'b0, 1'b1, 1'b0};
    pv = '{2, 2, 3, 0};
    bus.lookup_req = 1'b1;
    for (int i = 0; i < QD; i++) begin
      drive_upd(1'b1, 10 + i, tk[i], pv[i]);
      sb.push_back('{idx: IW'(10 + i), cnt: exp_cnt(pv[i], tk[i])});
      sample();
      n_checks++;
      if (bus.upd_ready !== 1'b1) begin
        n_errors++;
        $display("FAIL fill_ready slot=%0d got=%b expected=1", i, bus.upd_ready);
      end
      step();
    end
    drive_upd(1'b1, 14, 1'b1, 1);
    sample();
    n_checks++;
    if (bus.upd_ready !== 1'b0 || bus.q_count !== 3'd4 || bus.pht_we !== 1'b0) begin
      n_errors++;
      $display("FAIL full got ready=%b q=%0d we=%b, expected 0 4 0", bus.upd_ready, bus.q_count, bus.pht_we);
    end
    step();
    drive_upd(1'b0, 0, 1'b0, 0);
    bus.lookup_req = 1'b0;
    sample();
    n_checks++;
    if (bus.upd_ready !== 1'b0 || bus.pht_we !== 1'b1) begin
      n_errors++;
      $display("FAIL release got ready=%b we=%b, expected 0 1", bus.upd_ready, bus.pht_we);
    end
    step();
    sample();
    n_checks++;
    if (bus.upd_ready !== 1'b1 || bus.q_count !== 3'd3) begin
      n_errors++;
      $display("FAIL ready_return got ready=%b q=%0d, expected 1 3", bus.upd_ready, bus.q_count);
    end
    step();
    drain(10);
  endtask

  task automatic test_reset_mid();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample();
      step();
    end
    sample();
    n_checks++;
    if (bus.pht_waddr !== 4'd7 || bus.init_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_sweep_ptr got addr=%0d busy=%b, expected 7 1", bus.pht_waddr, bus.init_busy);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.pht_we !== 1'b0 || bus.init_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL mid_sweep_rst got we=%b busy=%b, expected 0 1", bus.pht_we, bus.init_busy);
    end
    step();
    rst = 1'b0;
    run_sweep("resweep");

    bus.lookup_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_upd(1'b1, 1 + i, 1'b1, 1);
      sb.push_back('{idx: IW'(1 + i), cnt: exp_cnt(1, 1'b1)});
      sample();
      step();
    end
    drive_upd(1'b0, 0, 1'b0, 0);
    sample();
    n_checks++;
    if (bus.q_count !== 3'd3) begin
      n_errors++;
      $display("FAIL queued3 got q=%0d expected=3", bus.q_count);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.q_count !== 3'd0 || bus.pht_we !== 1'b0 || bus.upd_ready !== 1'b0) begin
      n_errors++;
      $display("FAIL queue_rst got q=%0d we=%b ready=%b, expected 0 0 0", bus.q_count, bus.pht_we, bus.upd_ready);
    end
    sb.delete();
    step();
    rst = 1'b0;
    run_sweep("postq");
    bus.lookup_req = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sample();
      step();
    end
    drain(1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    #1;
    test_reset();
    test_single();
    test_forward();
    test_starve();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
